// File: rtl/tile_store_sched.sv
// Walks C in TILE_SIZE tiles, issuing one store per filled ping-pong bank; start follows wr_done by 3 cycles.
// Backpressure: bank_avail drops at 2 pending banks; waits on st_wr_done before moving on.
module tile_store_sched #(
  parameter int TILE_SIZE  = 8,
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 16,
  parameter int ELEM_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 job_start,
  input  logic [DIM_W-1:0]     job_n,
  input  logic [DIM_W-1:0]     job_m,
  input  logic [ADDR_W-1:0]    job_base_c,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*DIM_W-1:0]   tiles_done,
  input  logic                 tile_ready,
  output logic                 bank_avail,
  output logic                 st_start_store,
  output logic [ADDR_W-1:0]    st_base_c_addr,
  output logic [31:0]          st_stride_c_row_bytes,
  output logic [DIM_W-1:0]     st_i0,
  output logic [DIM_W-1:0]     st_j0,
  output logic [3:0]           st_n_eff,
  output logic [3:0]           st_m_eff,
  input  logic                 st_wr_done
);

  typedef enum logic [2:0] {
    IDLE, WAIT_TILE, ISSUE, WAIT_DONE, ADVANCE, FINISH
  } state_t;

  localparam logic [DIM_W:0]     TILE_X = (DIM_W+1)'(TILE_SIZE);
  localparam logic [2*DIM_W-1:0] TD_ONE = (2*DIM_W)'(1);

  state_t             state, state_nxt;
  logic [1:0]         pending;
  logic [DIM_W-1:0]   n_r, m_r;
  logic [DIM_W:0]     i_nxt, j_nxt;
  logic               last_col, last_row, job_zero;

  // One extra bit keeps the edge test exact for dimensions near 2^DIM_W.
  function automatic logic [3:0] edge_eff(input logic [DIM_W-1:0] dim,
                                          input logic [DIM_W-1:0] org);
    logic [DIM_W:0] rem;
    rem = {1'b0, dim} - {1'b0, org};
    return (rem >= TILE_X) ? 4'(TILE_SIZE) : rem[3:0];
  endfunction

  assign i_nxt      = {1'b0, st_i0} + TILE_X;
  assign j_nxt      = {1'b0, st_j0} + TILE_X;
  assign last_col   = j_nxt >= {1'b0, m_r};
  assign last_row   = i_nxt >= {1'b0, n_r};
  assign job_zero   = (job_n == '0) || (job_m == '0);
  assign bank_avail = pending < 2'd2;

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    st_start_store = 1'b0;
    done           = 1'b0;
    busy           = 1'b0;
    unique case (state)
      IDLE:      if (job_start) state_nxt = job_zero ? FINISH : WAIT_TILE;
      WAIT_TILE: begin
        busy = 1'b1;
        if (pending != 2'd0) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy           = 1'b1;
        st_start_store = 1'b1;
        state_nxt      = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (st_wr_done) state_nxt = ADVANCE;
      end
      ADVANCE: begin
        busy      = 1'b1;
        state_nxt = (last_col && last_row) ? FINISH : WAIT_TILE;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pending               <= 2'd0;
      err                   <= 1'b0;
      tiles_done            <= '0;
      n_r                   <= '0;
      m_r                   <= '0;
      st_base_c_addr        <= '0;
      st_stride_c_row_bytes <= '0;
      st_i0                 <= '0;
      st_j0                 <= '0;
      st_n_eff              <= '0;
      st_m_eff              <= '0;
    end else begin
      unique case (state)
        IDLE: if (job_start) begin
          tiles_done <= '0;
          err        <= 1'b0;
          if (!job_zero) begin
            n_r                   <= job_n;
            m_r                   <= job_m;
            st_base_c_addr        <= job_base_c;
            st_stride_c_row_bytes <= 32'(job_m) * 32'(ELEM_BYTES);
            st_i0                 <= '0;
            st_j0                 <= '0;
            st_n_eff              <= edge_eff(job_n, '0);
            st_m_eff              <= edge_eff(job_m, '0);
          end
        end
        WAIT_DONE: if (st_wr_done) tiles_done <= tiles_done + TD_ONE;
        ADVANCE: if (!(last_col && last_row)) begin
          if (last_col) begin
            st_j0    <= '0;
            st_i0    <= i_nxt[DIM_W-1:0];
            st_n_eff <= edge_eff(n_r, i_nxt[DIM_W-1:0]);
            st_m_eff <= edge_eff(m_r, '0);
          end else begin
            st_j0    <= j_nxt[DIM_W-1:0];
            st_m_eff <= edge_eff(m_r, j_nxt[DIM_W-1:0]);
          end
        end
        // Leftover banks at the end of a real job mean the producer over-filled.
        FINISH: if (tiles_done != '0 && pending != 2'd0) err <= 1'b1;
        default: ;
      endcase

      if (st_wr_done && state != WAIT_DONE) err <= 1'b1;

      if (tile_ready && !st_start_store) begin
        if (pending == 2'd2) err <= 1'b1;
        else                 pending <= pending + 2'd1;
      end else if (!tile_ready && st_start_store) begin
        pending <= pending - 2'd1;
      end
    end
  end

endmodule
